// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div -- multi-cycle 32-bit integer divider (restoring, one quotient bit per
// cycle) for the EX stage DIV/DIVU path.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed divide, 0 = unsigned divide
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       abort the current operation (pipeline flush)
//   result_o      {remainder, quotient}, valid only while ready_o = 1
//   ready_o       result valid (registered)
//
// Handshake: EX raises start_i with stable operands and keeps it high until
// it observes ready_o = 1; it then drops start_i, which returns the block to
// FREE on the next edge. Dropping start_i early (or annul_i) aborts.
//
// Optional feature: define DIV_ZERO_SHORTCUT_EN to build the BYZERO state,
// which answers a zero divisor with 64'h0 after two edges. Without it a zero
// divisor runs the full 32 steps like any other operand pair.
// ---------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;      // dividend bits shift out the top, quotient bits in at the bottom
    logic [31:0] dvs_q;      // divisor magnitude
    logic [31:0] rem_q;      // partial remainder
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] trial;
    logic [31:0] rem_d;
    logic [31:0] dvd_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes; 0x80000000 negates to itself and is then treated
    // as an unsigned magnitude, which gives the right answer.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // One restoring step: a non-negative trial difference commits and
    // produces a 1 quotient bit, otherwise the shifted remainder is kept.
    always_comb begin
        trial = {rem_q, dvd_q[31]} - {1'b0, dvs_q};
        if (!trial[32]) begin
            rem_d = trial[31:0];
            dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
            rem_d = {rem_q[30:0], dvd_q[31]};
            dvd_d = {dvd_q[30:0], 1'b0};
        end
        quo_fix = neg_quo_q ? (~dvd_d + 32'd1) : dvd_d;
        rem_fix = neg_rem_q ? (~rem_d + 32'd1) : rem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FREE;
            cnt_q     <= 5'd0;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            rem_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FREE: begin
                    if (start_i && !annul_i) begin
`ifdef DIV_ZERO_SHORTCUT_EN
                        if (opdata2_i == 32'd0) begin
                            state_q <= ST_BYZERO;
                        end else begin
                            state_q <= ST_ON;
                        end
`else
                        state_q <= ST_ON;
`endif
                        dvd_q     <= mag1;
                        dvs_q     <= mag2;
                        rem_q     <= 32'd0;
                        cnt_q     <= 5'd0;
                        neg_quo_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_q <= signed_div_i && opdata1_i[31];
                    end
                end
`ifdef DIV_ZERO_SHORTCUT_EN
                ST_BYZERO: begin
                    if (annul_i || !start_i) begin
                        state_q <= ST_FREE;
                        dvd_q   <= 32'd0;
                        dvs_q   <= 32'd0;
                        rem_q   <= 32'd0;
                    end else begin
                        state_q  <= ST_END;
                        result_q <= 64'd0;
                        ready_q  <= 1'b1;
                    end
                end
`endif
                ST_ON: begin
                    if (annul_i || !start_i) begin
                        state_q <= ST_FREE;
                        cnt_q   <= 5'd0;
                        dvd_q   <= 32'd0;
                        dvs_q   <= 32'd0;
                        rem_q   <= 32'd0;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q  <= ST_END;
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    // annul_i is deliberately ignored here: the result is
                    // already architecturally complete.
                    if (!start_i) begin
                        state_q  <= ST_FREE;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_FREE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: vector table, randomized operands against a
// plain-arithmetic model, plus abort / reset / hold sequences.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  // Reference: magnitudes, plain / and %, then sign rules.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
    if (mb == 32'd0) begin
`ifdef DIV_ZERO_SHORTCUT_EN
      return 64'd0;
`else
      q = 32'hFFFF_FFFF;
      r = ma;
`endif
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Edges from raising start_i until ready_o is visible (E0 counts as one).
  function automatic int model_lat(input logic [31:0] b);
`ifdef DIV_ZERO_SHORTCUT_EN
    if (b == 32'd0) return 2;
`endif
    return 33;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one full transaction, operands scrambled after acceptance
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int hold);
    int n;
    int lat;
    lat = model_lat(b);
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    n = 0;
    while (!ready && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = $urandom_range(0, 1);
      end
    end
    chk({name, "_ready"}, 64'(ready), 64'd1);
    chk({name, "_lat"}, 64'(n), 64'(lat));
    chk({name, "_result"}, result, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, "_hold_ready"}, 64'(ready), 64'd1);
      chk({name, "_hold_result"}, result, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, "_drop_ready"}, 64'(ready), 64'd0);
    chk({name, "_drop_result"}, result, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // table: inputs and hand-derived expected results
    vecs.push_back('{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  64'hFFFFFFFF_FFFFFFFD});
    vecs.push_back('{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  64'h00000001_FFFFFFFD});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  64'h00000000_FFFFFFFF});
    vecs.push_back('{1'b0, 32'd5,          32'd9,          64'h00000005_00000000});
`ifdef DIV_ZERO_SHORTCUT_EN
    vecs.push_back('{1'b0, 32'h1234_5678,  32'd0,          64'h0});
`else
    vecs.push_back('{1'b0, 32'h1234_5678,  32'd0,          64'h12345678_FFFFFFFF});
`endif
    foreach (vecs[i]) begin
      run_div($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 3 : 0);
    end

    // randomized operands against the model
    for (int i = 0; i < 40; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 15);
        1: b = 32'd0 - 32'($urandom_range(1, 15));
        2: b = (i % 10 == 0) ? 32'd0 : $urandom;
        default: b = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), s, a, b, model(s, a, b), 0);
    end

    // annul at iteration 10
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      chk("annul_idle_ready", 64'(ready), 64'd0);
      if (ready) break;
    end
    run_div("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);

    // reset at iteration 20
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_result", result, 64'd0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    run_div("after_rst", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving the EX stage's DIV/DIVU path. It accepts a start request with two operands and a signed/unsigned flag, and iterates one quotient bit per cycle using restoring division. When done, it returns the remainder and quotient as one 64-bit word, laid out as {HI, LO}. It sits beside EX, which holds its stall request until `ready_o` is seen.

## Interface
- No parameters; width is fixed at 32.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by EX until `ready_o` is seen.
- `annul_i`  in  1  abort the current operation (pipeline flush).
- `result_o`  out  64  {remainder[31:0], quotient[31:0]}; valid only while `ready_o`=1.
- `ready_o`  out  1  result valid.

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor zero.
  - ON: iterating.
  - END: result held.
- FREE:
  - `start_i`=1, `annul_i`=0, `opdata2_i`≠0: latch operand magnitudes and sign flags; clear `cnt`; go to ON.
  - Same, but `opdata2_i`=0: go to BYZERO (see Configuration).
  - Otherwise stay in FREE.
- Magnitudes: if `signed_div_i` and the operand's bit 31 is set, take ~op+1, else op. 0x80000000 stays 0x80000000 and is treated as unsigned.
- Operand or flag changes after latching are ignored.
- ON, one step per cycle:
  - Form the 33-bit trial difference {rem, dvd[31]} − {0, divisor}.
  - If non-negative: rem ← diff[31:0], shift 1 into the quotient.
  - Otherwise: rem ← {rem[30:0], dvd[31]}, shift 0 into the quotient.
  - `cnt` increments each step. The step with `cnt`=31 is the last one and moves to END.
- END entry, sign correction:
  - Quotient is negated if signed and op1[31]^op2[31].
  - Remainder is negated if signed and op1[31].
  - `result_o` is registered and `ready_o` goes to 1.
- END:
  - `start_i`=0: go to FREE; `ready_o`←0, `result_o`←0.
  - `start_i`=1: stay; `result_o` and `ready_o` held.
- Abort: in ON or BYZERO, `annul_i`=1 or `start_i`=0 sends the block to FREE with outputs 0 and discards partial state.
- `annul_i`=1 in FREE blocks a start that cycle.
- `annul_i` in END is ignored; only `start_i`=0 releases END.
- Reset dominates every state: state=FREE, `ready_o`=0, `result_o`=0, `cnt`=0, datapath registers 0.

## Timing
- Start accepted on edge E0.
- Iterations run on edges E1..E32. `ready_o`=1 and the result are visible after E32, i.e. 32 cycles after acceptance.
- Divide-by-zero shortcut: BYZERO at E0, END at E1, `ready_o` visible after E1.
- `ready_o` is registered; no combinational path from inputs to outputs.
- EX drops `start_i` in the cycle it sees `ready_o`. The next edge returns the block to FREE, so `ready_o` is high for exactly one cycle in normal flow.
- A new start can be accepted on the edge after returning to FREE. There is no back-to-back acceptance from END.

## Configuration
- `DIV_ZERO_SHORTCUT_EN` defined:
  - Divisor 0 takes the BYZERO path.
  - Result is 64'h0 after 2 edges.
- Not defined:
  - BYZERO is not built; divisor 0 enters ON and runs the full 32 steps.
  - Every trial succeeds, so the raw result is quotient 32'hFFFFFFFF, remainder |dividend|, followed by normal sign correction.
  - Unsigned result: {opdata1_i, 32'hFFFFFFFF}.
  - Latency is 32 cycles.

## Test plan
- Unsigned 100/7:
  - `ready_o` rises 32 cycles after acceptance with `result_o`=64'h00000002_0000000E.
  - Drop `start_i` → next edge gives `ready_o`=0, `result_o`=0.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → `result_o`=64'hFFFFFFFF_FFFFFFFD. Signed 7/−2 → 64'h00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
- Unsigned 0xFFFFFFFF/1 → 64'h00000000_FFFFFFFF.
- Divisor 0, dividend 0x12345678, unsigned:
  - With macro: `ready_o` after 2 edges, `result_o`=0.
  - Without macro: after 32 cycles, 64'h12345678_FFFFFFFF.
- Abort and reset:
  - Assert `annul_i` at iteration 10 → FREE, `ready_o` stays 0. A fresh 100/7 then takes the full 32 cycles with the correct result.
  - Assert `rst` at iteration 20 → all outputs 0 on the next edge; the next request completes normally.
